hs32_mem_arb: RTL and testbench

- Two-master memory arbiter sharing one external memory port between the fetch unit (read-only) and the execute unit (read/write).
- Sits between hs32_fetch / hs32_exec and the SRAM/bus controller.
- Registers the winning request, holds it stable on the memory side until the memory acknowledges, then returns data with a one-cycle ready pulse.
- Alternates priority on contention and aborts stalled accesses after a timeout.

---
 rtl/hs32_mem_arb.sv | 158 +++++++++++++++
 tb/tb_hs32_mem_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb
// Arbitrates one external memory port between the fetch unit (read-only)
// and the execute unit (read/write). The winning request is registered and
// held on the memory side until the memory acknowledges. The result is then
// returned with a one-cycle ready pulse. On contention the priority
// alternates, and a stalled access is aborted after TIMEOUT cycles.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   f_req/f_addr        fetch read request and address (held until f_rdy)
//   f_rdy/f_dtr         fetch done pulse and read data
//   x_req/x_rw/x_addr   execute request, direction (1=write) and address
//   x_dtw               execute write data
//   x_rdy/x_dtr         execute done pulse and read data
//   m_req/m_rw/m_addr   memory request, direction and address (registered)
//   m_dtw               memory write data (registered)
//   m_dtr/m_rdy         memory read data and acknowledge
//   busy                high while an access is in flight (BUSY or DONE)
//   fault               pulses with the rdy of an access that timed out
module hs32_mem_arb #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_rdy,
  output logic [31:0] f_dtr,
  input  logic        x_req,
  input  logic        x_rw,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_dtw,
  output logic        x_rdy,
  output logic [31:0] x_dtr,
  output logic        m_req,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  input  logic [31:0] m_dtr,
  input  logic        m_rdy,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT);
  localparam bit            TMO_EN  = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_rw_q, m_rw_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_dtw_q, m_dtw_d;
  logic [31:0]   data_q, data_d;
  logic          grant_x_q, grant_x_d;
  logic          last_x_q, last_x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_flag_q, fault_flag_d;
  logic          pick_x;

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_rw_d       = m_rw_q;
    m_addr_d     = m_addr_q;
    m_dtw_d      = m_dtw_q;
    data_d       = data_q;
    grant_x_d    = grant_x_q;
    last_x_d     = last_x_q;
    cnt_d        = cnt_q;
    fault_flag_d = fault_flag_q;
    // Execute wins when it is alone, or when both request and fetch was
    // served last; otherwise fetch wins.
    pick_x       = x_req && (!f_req || !last_x_q);

    case (state_q)
      IDLE: begin
        if (x_req || f_req) begin
          grant_x_d    = pick_x;
          last_x_d     = pick_x;
          m_addr_d     = pick_x ? x_addr : f_addr;
          m_dtw_d      = x_dtw;
          m_rw_d       = pick_x & x_rw;   // fetch is always a read
          m_req_d      = 1'b1;
          cnt_d        = '0;
          fault_flag_d = 1'b0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // An acknowledge on the last allowed cycle still wins over the abort.
        if (m_rdy) begin
          data_d  = m_dtr;
          m_req_d = 1'b0;
          state_d = DONE;
        end else if (TMO_EN && (cnt_q == TMO_LIM)) begin
          data_d       = 32'hFFFF_FFFF;
          fault_flag_d = 1'b1;
          m_req_d      = 1'b0;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        fault_flag_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      m_req_q      <= 1'b0;
      m_rw_q       <= 1'b0;
      m_addr_q     <= '0;
      m_dtw_q      <= '0;
      data_q       <= '0;
      grant_x_q    <= 1'b0;
      last_x_q     <= 1'b0;
      cnt_q        <= '0;
      fault_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_rw_q       <= m_rw_d;
      m_addr_q     <= m_addr_d;
      m_dtw_q      <= m_dtw_d;
      data_q       <= data_d;
      grant_x_q    <= grant_x_d;
      last_x_q     <= last_x_d;
      cnt_q        <= cnt_d;
      fault_flag_q <= fault_flag_d;
    end
  end

  assign m_req  = m_req_q;
  assign m_rw   = m_rw_q;
  assign m_addr = m_addr_q;
  assign m_dtw  = m_dtw_q;
  assign f_dtr  = data_q;
  assign x_dtr  = data_q;
  assign f_rdy  = (state_q == DONE) && !grant_x_q;
  assign x_rdy  = (state_q == DONE) && grant_x_q;
  assign fault  = (state_q == DONE) && fault_flag_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Bench for hs32_mem_arb (TIMEOUT=4). A responder process plays the memory
// with a programmable number of wait states. Expected transactions go into a
// scoreboard queue when they are issued. A monitor pops an entry on every rdy
// pulse and compares it, and it checks the memory-side outputs while m_req
// is high.
module tb_hs32_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_rdy, x_req, x_rw, x_rdy, m_req, m_rw, m_rdy, busy, fault;
  logic [31:0] f_addr, f_dtr, x_addr, x_dtw, x_dtr, m_addr, m_dtw, m_dtr;

  always #5 clk = ~clk;

  hs32_mem_arb #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdy(f_rdy), .f_dtr(f_dtr),
    .x_req(x_req), .x_rw(x_rw), .x_addr(x_addr), .x_dtw(x_dtw),
    .x_rdy(x_rdy), .x_dtr(x_dtr),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw),
    .m_dtr(m_dtr), .m_rdy(m_rdy), .busy(busy), .fault(fault)
  );

  typedef struct {
    logic        is_x;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    int          waits;     // 99 = memory never acknowledges
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_lat;   // cycles from request seen to rdy, plus one
  } vec_t;

  typedef struct {
    logic        is_x;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   wait_cfg = 0;
  logic force_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents as seen by the responder.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic vec_t mk(input logic is_x, input logic rw, input logic [31:0] addr,
                              input logic [31:0] dtw, input int waits,
                              input logic [31:0] d, input logic flt, input int lat);
    vec_t v;
    v.is_x = is_x; v.rw = rw; v.addr = addr; v.dtw = dtw; v.waits = waits;
    v.exp_data = d; v.exp_fault = flt; v.exp_lat = lat;
    return v;
  endfunction

  // Memory responder: acknowledges after wait_cfg wait cycles.
  initial begin
    int wcnt;
    wcnt  = 0;
    m_rdy = 1'b0;
    m_dtr = 32'h0;
    forever begin
      @(negedge clk);
      m_rdy = force_rdy;
      if (force_rdy) m_dtr = 32'h5555_AAAA;
      if (m_req && !reset) begin
        if (wcnt == wait_cfg) begin
          m_rdy = 1'b1;
          m_dtr = mem_rd(m_addr);
          wcnt  = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_req) begin
          if (sb_q.size() == 0) begin
            chk("m_req_unexpected", {31'b0, m_req}, 32'h0);
          end else begin
            chk("m_addr", m_addr, sb_q[0].addr);
            chk("m_rw", {31'b0, m_rw}, {31'b0, sb_q[0].rw});
            if (sb_q[0].rw) chk("m_dtw", m_dtw, sb_q[0].dtw);
          end
        end
        if (f_rdy || x_rdy) begin
          chk("rdy_onehot", {31'b0, f_rdy & x_rdy}, 32'h0);
          if (sb_q.size() == 0) begin
            chk("rdy_unexpected", {30'b0, f_rdy, x_rdy}, 32'h0);
          end else begin
            e = sb_q.pop_front();
            $display("txn %s %s addr=%h data=%h fault=%0b", e.is_x ? "X" : "F",
                     e.rw ? "WR" : "RD", e.addr, e.is_x ? x_dtr : f_dtr, fault);
            chk("rdy_master", {31'b0, x_rdy}, {31'b0, e.is_x});
            if (!e.rw) chk("rd_data", e.is_x ? x_dtr : f_dtr, e.data);
            chk("fault", {31'b0, fault}, {31'b0, e.fault});
          end
        end else begin
          chk("fault_no_rdy", {31'b0, fault}, 32'h0);
        end
      end
    end
  end

  // Issue one transaction from an IDLE cycle and wait (bounded) for its rdy.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   lat, nreq;
    bit   seen;
    wait_cfg = v.waits;
    e.is_x = v.is_x; e.rw = v.is_x & v.rw; e.addr = v.addr; e.dtw = v.dtw;
    e.data = v.exp_data; e.fault = v.exp_fault;
    sb_q.push_back(e);
    if (v.is_x) begin
      x_rw = v.rw; x_addr = v.addr; x_dtw = v.dtw; x_req = 1'b1;
    end else begin
      f_addr = v.addr; f_req = 1'b1;
    end
    lat = 0; nreq = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_req) nreq++;
      chk({tag, "_busy"}, {31'b0, busy}, 32'h1);
      if (v.is_x ? x_rdy : f_rdy) seen = 1;
    end
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_mreq_cycles"}, nreq, v.exp_lat - 1);
    x_req = 1'b0;
    f_req = 1'b0;
    @(negedge clk);   // DONE -> IDLE
  endtask

  initial begin
    vec_t vecs[9];
    int   nx, nf, cyc, last;

    vecs[0] = mk(1'b0, 1'b0, 32'h0000_0100, 32'h0,          0, 32'hDEAD_BEEF, 1'b0, 2);
    vecs[1] = mk(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678,  3, 32'h0,         1'b0, 5);
    vecs[2] = mk(1'b1, 1'b0, 32'h0000_3000, 32'h0,          0, 32'hA5A5_3000, 1'b0, 2);
    vecs[3] = mk(1'b0, 1'b0, 32'h0000_0044, 32'h0,          1, 32'hA5A5_0044, 1'b0, 3);
    vecs[4] = mk(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D,  0, 32'h0,         1'b0, 2);
    vecs[5] = mk(1'b1, 1'b0, 32'h0000_0500, 32'h0,         99, 32'hFFFF_FFFF, 1'b1, 6);
    vecs[6] = mk(1'b0, 1'b0, 32'h0000_0600, 32'h0,          0, 32'hA5A5_0600, 1'b0, 2);
    vecs[7] = mk(1'b0, 1'b0, 32'h0000_0700, 32'h0,          4, 32'hA5A5_0700, 1'b0, 6);
    vecs[8] = mk(1'b0, 1'b0, 32'h0000_0800, 32'h0,         99, 32'hFFFF_FFFF, 1'b1, 6);

    reset = 1'b1;
    f_req = 1'b0; f_addr = 32'h0;
    x_req = 1'b0; x_rw = 1'b0; x_addr = 32'h0; x_dtw = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", {31'b0, m_req}, 32'h0);
    chk("rst_m_rw", {31'b0, m_rw}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_dtw", m_dtw, 32'h0);
    chk("rst_rdy", {30'b0, f_rdy, x_rdy}, 32'h0);
    chk("rst_busy_fault", {30'b0, busy, fault}, 32'h0);
    chk("rst_f_dtr", f_dtr, 32'h0);
    chk("rst_x_dtr", x_dtr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious acknowledge while idle.
    force_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) force_rdy = 1'b0;
      chk("spur_busy", {31'b0, busy}, 32'h0);
      chk("spur_m_req", {31'b0, m_req}, 32'h0);
      chk("spur_rdy", {30'b0, f_rdy, x_rdy}, 32'h0);
    end

    // Reset in the middle of a stalled access.
    wait_cfg = 99;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_0900, 32'h0, 32'h0, 1'b0});
    x_rw = 1'b0; x_addr = 32'h0000_0900; x_req = 1'b1;
    @(negedge clk);
    chk("mid_m_req", {31'b0, m_req}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    x_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_req", {31'b0, m_req}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_rdy", {30'b0, f_rdy, x_rdy}, 32'h0);
    chk("mid_rst_dtr", x_dtr, 32'h0);
    sb_q.delete();
    reset = 1'b0;
    @(negedge clk);
    run_vec(mk(1'b0, 1'b0, 32'h0000_0040, 32'h0, 0, 32'hA5A5_0040, 1'b0, 2), "after_rst");

    // Contention with both requests held: X, F, X, F, rdy every 3 cycles.
    wait_cfg = 0;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'hA5A5_1000, 1'b0});
    sb_q.push_back('{1'b0, 1'b0, 32'h0000_1100, 32'h0, 32'hA5A5_1100, 1'b0});
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_1200, 32'h0, 32'hA5A5_1200, 1'b0});
    sb_q.push_back('{1'b0, 1'b0, 32'h0000_1300, 32'h0, 32'hA5A5_1300, 1'b0});
    x_rw = 1'b0; x_addr = 32'h0000_1000; f_addr = 32'h0000_1100;
    x_req = 1'b1; f_req = 1'b1;
    nx = 0; nf = 0; cyc = 0; last = -1;
    while ((nx < 2 || nf < 2) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (x_rdy || f_rdy) begin
        if (last >= 0) chk("contend_gap", cyc - last, 3);
        last = cyc;
      end
      if (x_rdy) begin
        nx++;
        if (nx == 2) x_req = 1'b0; else x_addr = 32'h0000_1200;
      end
      if (f_rdy) begin
        nf++;
        if (nf == 2) f_req = 1'b0; else f_addr = 32'h0000_1300;
      end
    end
    chk("contend_count", nx + nf, 4);
    chk("contend_sb_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
